// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: producer handshakes, register-file write port and hazard query bundle.
interface reg_writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  logic                    alu_valid;
  logic                    alu_ready;
  logic [ADDR_W-1:0]       alu_rd;
  logic [DATA_W-1:0]       alu_data;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_W-1:0]       mem_rd;
  logic [DATA_W-1:0]       mem_data;
  logic                    reg_write;
  logic [ADDR_W-1:0]       rd_add;
  logic [DATA_W-1:0]       write_reg_data;
  logic [ADDR_W-1:0]       rs1_add;
  logic [ADDR_W-1:0]       rs2_add;
  logic                    rs1_pending;
  logic                    rs2_pending;
  logic [$clog2(DEPTH):0]  count;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1_add, rs2_add,
    input  alu_ready, mem_ready, reg_write, rd_add, write_reg_data, rs1_pending, rs2_pending, count
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1_add, rs2_add,
    output alu_ready, mem_ready, reg_write, rd_add, write_reg_data, rs1_pending, rs2_pending, count
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: in-order FIFO merging ALU and load results into one register-file write per cycle.
module reg_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_rd_add;
  logic [DATA_W-1:0] r_wdata;
  logic              w_mem_ready, w_alu_ready, w_mem_push, w_alu_push, w_pop, w_p1, w_p2;
  logic [CW-1:0]     w_cnt_mem;
  logic [PW-1:0]     w_alu_wp;
  // load port claims the last free slot, so alu readiness counts a pending load
  assign w_mem_ready = r_cnt < CW'(DEPTH);
  assign w_cnt_mem   = r_cnt + CW'(bus.mem_valid && bus.mem_rd != '0);
  assign w_alu_ready = w_cnt_mem < CW'(DEPTH);
  assign w_mem_push  = bus.mem_valid && w_mem_ready && bus.mem_rd != '0;
  assign w_alu_push  = bus.alu_valid && w_alu_ready && bus.alu_rd != '0;
  assign w_pop       = r_cnt != '0;
  assign w_alu_wp    = r_wp + PW'(w_mem_push);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_vld    <= '0;
      r_we     <= 1'b0;
      r_rd_add <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_rd_add     <= r_rd[r_rp];
        r_wdata      <= r_data[r_rp];
        r_vld[r_rp]  <= 1'b0;
        r_rp         <= r_rp + PW'(1);
      end
      if (w_mem_push) r_vld[r_wp] <= 1'b1;
      if (w_alu_push) r_vld[w_alu_wp] <= 1'b1;
      r_wp  <= r_wp + PW'(w_mem_push) + PW'(w_alu_push);
      r_cnt <= r_cnt + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_rd[r_wp]   <= bus.mem_rd;
      r_data[r_wp] <= bus.mem_data;
    end
    if (w_alu_push) begin
      r_rd[w_alu_wp]   <= bus.alu_rd;
      r_data[w_alu_wp] <= bus.alu_data;
    end
  end
  always_comb begin
    w_p1 = r_we && r_rd_add == bus.rs1_add;
    w_p2 = r_we && r_rd_add == bus.rs2_add;
    for (int i = 0; i < DEPTH; i++) begin
      w_p1 = w_p1 | (r_vld[i] && r_rd[i] == bus.rs1_add);
      w_p2 = w_p2 | (r_vld[i] && r_rd[i] == bus.rs2_add);
    end
  end
  assign bus.alu_ready      = w_alu_ready;
  assign bus.mem_ready      = w_mem_ready;
  assign bus.reg_write      = r_we;
  assign bus.rd_add         = r_rd_add;
  assign bus.write_reg_data = r_wdata;
  assign bus.rs1_pending    = w_p1 && bus.rs1_add != '0;
  assign bus.rs2_pending    = w_p2 && bus.rs2_add != '0;
  assign bus.count          = r_cnt;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_reg_writeback_unit;
  localparam int DEPTH = 4;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  int wlog[$];
  bit m_we = 1'b0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_data = '0;
  reg_writeback_unit_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) w();
  reg_writeback_unit #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(w));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit pend(logic [4:0] a);
    if (a == 0) return 1'b0;
    if (m_we && m_rd == a) return 1'b1;
    foreach (q[i]) if (q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction
  always @(negedge clk) begin
    chk("reg_write", w.reg_write, m_we);
    chk("rd_add", w.rd_add, m_rd);
    chk("write_reg_data", w.write_reg_data, m_data);
    chk("count", w.count, q.size());
    chk("mem_ready", w.mem_ready, q.size() < DEPTH);
    chk("alu_ready", w.alu_ready, (q.size() + (w.mem_valid && w.mem_rd != 0)) < DEPTH);
    chk("rs1_pending", w.rs1_pending, pend(w.rs1_add));
    chk("rs2_pending", w.rs2_pending, pend(w.rs2_add));
    if (w.reg_write) wlog.push_back(int'(w.rd_add));
  end
  task automatic model_reset();
    q.delete();
    m_we = 1'b0;
    m_rd = '0;
    m_data = '0;
  endtask
  task automatic cyc();
    bit ma, aa;
    ma = w.mem_valid && q.size() < DEPTH;
    aa = w.alu_valid && (q.size() + (w.mem_valid && w.mem_rd != 0)) < DEPTH;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_we = q.size() > 0;
      if (m_we) begin
        m_rd = q[0].rd;
        m_data = q[0].data;
        void'(q.pop_front());
      end
      if (ma && w.mem_rd != 0) q.push_back('{w.mem_rd, w.mem_data});
      if (aa && w.alu_rd != 0) q.push_back('{w.alu_rd, w.alu_data});
    end
    #1;
  endtask
  task automatic drive(bit mv, logic [4:0] mr, logic [31:0] md, bit av, logic [4:0] ar, logic [31:0] ad);
    w.mem_valid = mv; w.mem_rd = mr; w.mem_data = md;
    w.alu_valid = av; w.alu_rd = ar; w.alu_data = ad;
  endtask
  initial begin
    int exp_log[$];
    drive(0, 0, 0, 0, 0, 0);
    w.rs1_add = 0;
    w.rs2_add = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_count", w.count, 0);
    chk("reset_reg_write", w.reg_write, 0);
    chk("reset_wdata", w.write_reg_data, 0);
    // single ALU write to x5
    w.rs1_add = 5;
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s1_count", w.count, 1);
    chk("s1_pend_queued", w.rs1_pending, 1);
    chk("s1_no_write_yet", w.reg_write, 0);
    cyc();
    chk("s1_we", w.reg_write, 1);
    chk("s1_rd", w.rd_add, 5);
    chk("s1_data", w.write_reg_data, 32'hDEADBEEF);
    chk("s1_pend_writing", w.rs1_pending, 1);
    cyc();
    chk("s1_we_off", w.reg_write, 0);
    chk("s1_pend_clear", w.rs1_pending, 0);
    // simultaneous mem x4 and alu x3
    w.rs1_add = 3; w.rs2_add = 4;
    drive(1, 4, 32'h22, 1, 3, 32'h11);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s2_count2", w.count, 2);
    cyc();
    chk("s2_first_rd", w.rd_add, 4);
    chk("s2_first_data", w.write_reg_data, 32'h22);
    chk("s2_count1", w.count, 1);
    cyc();
    chk("s2_second_rd", w.rd_add, 3);
    chk("s2_second_data", w.write_reg_data, 32'h11);
    chk("s2_count0", w.count, 0);
    cyc();
    // fill to DEPTH-1; load wins the last slot
    wlog.delete();
    w.rs1_add = 22; w.rs2_add = 13;
    drive(1, 10, 32'hA0, 1, 20, 32'hB0); cyc();
    chk("s3_count2", w.count, 2);
    drive(1, 11, 32'hA1, 1, 21, 32'hB1); cyc();
    chk("s3_count3", w.count, 3);
    drive(1, 12, 32'hA2, 1, 22, 32'hB2); #1;
    chk("s3_alu_blocked", w.alu_ready, 0);
    chk("s3_mem_ready", w.mem_ready, 1);
    cyc();
    drive(1, 13, 32'hA3, 1, 22, 32'hB2); #1;
    chk("s3_alu_blocked2", w.alu_ready, 0);
    cyc();
    drive(0, 0, 0, 1, 22, 32'hB2); #1;
    chk("s3_alu_ready", w.alu_ready, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s3_count_after", w.count, 3);
    for (int i = 0; i < 5; i++) cyc();
    exp_log = '{10, 20, 11, 21, 12, 13, 22};
    chk("s3_nwrites", wlog.size(), exp_log.size());
    foreach (exp_log[i]) if (i < wlog.size()) chk("s3_order", wlog[i], exp_log[i]);
    // x0 result is consumed but dropped
    wlog.delete();
    w.rs1_add = 0; w.rs2_add = 0;
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFF); #1;
    chk("s4_alu_ready", w.alu_ready, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s4_count", w.count, 0);
    chk("s4_pend0", w.rs1_pending, 0);
    cyc(); cyc();
    chk("s4_no_writes", wlog.size(), 0);
    // back-to-back x7
    w.rs1_add = 7;
    drive(0, 0, 0, 1, 7, 32'h1); cyc();
    chk("s5_pend_a", w.rs1_pending, 1);
    drive(0, 0, 0, 1, 7, 32'h2); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s5_first", w.write_reg_data, 32'h1);
    chk("s5_pend_b", w.rs1_pending, 1);
    cyc();
    chk("s5_second", w.write_reg_data, 32'h2);
    chk("s5_pend_c", w.rs1_pending, 1);
    cyc();
    chk("s5_pend_clear", w.rs1_pending, 0);
    // async reset while draining with three queued
    w.rs1_add = 9;
    drive(1, 1, 32'h1, 1, 2, 32'h2); cyc();
    drive(1, 6, 32'h6, 1, 8, 32'h8); cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("s6_count3", w.count, 3);
    chk("s6_draining", w.reg_write, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("s6_rst_we", w.reg_write, 0);
    chk("s6_rst_count", w.count, 0);
    chk("s6_rst_rd", w.rd_add, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("s6_no_write", w.reg_write, 0);
    drive(0, 0, 0, 1, 9, 32'h55); cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("s6_new_we", w.reg_write, 1);
    chk("s6_new_rd", w.rd_add, 9);
    chk("s6_new_data", w.write_reg_data, 32'h55);
    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
Writer side of the 32x32 register file write port (reg_write / rd_add / write_reg_data). It accepts results from two producers, the ALU and the memory/load unit, through valid/ready handshakes. Results are buffered in an in-order FIFO and drained as one register-file write per cycle. It also reports whether a source register still has a write outstanding, so issue logic can stall on it.

Parameters:
DATA_W, 32, result/register data width
ADDR_W, 5, register address width (32 registers)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
alu_valid  input  1  ALU result valid
alu_ready  output  1  unit can accept ALU result this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result valid
mem_ready  output  1  unit can accept load result this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load result
reg_write  output  1  register file write enable (registered)
rd_add  output  ADDR_W  register file write address (registered)
write_reg_data  output  DATA_W  register file write data (registered)
rs1_add  input  ADDR_W  hazard query address 1
rs2_add  input  ADDR_W  hazard query address 2
rs1_pending  output  1  write to rs1_add still outstanding
rs2_pending  output  1  write to rs2_add still outstanding
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous: reg_write=0, rd_add=0, write_reg_data=0, FIFO empty (count=0), read/write pointers=0. Any entry in flight at reset is discarded, with no write issued.
- Transfer occurs when valid&&ready are sampled high at the rising edge of clk.
- mem_ready = (count < DEPTH).
- alu_ready = (count + (mem_valid && mem_rd!=0)) < DEPTH. The load port has priority for the last free slot.
- Ready signals use pre-pop occupancy. A pop in the same cycle does not raise ready (conservative by design).
- Simultaneous accept of both ports: the mem entry is enqueued first, the alu entry second. Both are enqueued in the same edge.
- An accepted entry with rd=0 is consumed (handshake completes) but not enqueued. x0 is never written, and its pending bit is never set.
- Drain: on every edge where the FIFO is non-empty, pop the head into the output registers and set reg_write=1. If the FIFO is empty, reg_write=0; rd_add and write_reg_data hold their last values.
- At most one write is issued per cycle. Pushing up to 2 and popping 1 in the same edge is legal, and count updates by the net change.
- Latency: a result accepted at edge N into an empty FIFO is popped at edge N+1, so reg_write is high during cycle N+1..N+2. Minimum 2 edges from accept to the register file write edge.
- Order: writes are issued in acceptance order. Two writes to the same rd arrive in order, and the last one wins.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Pending (combinational): rsX_pending=1 iff rsX_add!=0 and rsX_add matches either of:
  - the rd of any valid FIFO entry;
  - rd_add while reg_write=1.
- Pending covers through the register-file write edge. Pending does not include a handshake in the current cycle.

Test Plan:
- Single ALU result x5=0xDEADBEEF into idle unit -> reg_write pulses exactly one cycle, 2 edges after accept, rd_add=5, write_reg_data=0xDEADBEEF. rs1_pending(5)=1 from the edge after accept until the end of the write cycle.
- alu (x3=0x11) and mem (x4=0x22) valid in the same cycle, FIFO empty -> both accepted; writes are x4 then x3 on consecutive cycles; count goes 2,1,0.
- Fill with mem holding reg_write off by keeping results flowing; hold both valid at count=DEPTH-1 -> mem accepted, alu_ready=0; alu accepted only after count drops.
- alu_rd=0, data 0xFFFFFFFF -> handshake completes, count stays 0, reg_write never asserts, rs1_pending(0)=0.
- Back-to-back writes to x7 (0x1 then 0x2) -> two writes in order, final value 0x2; rs1_pending(7) stays 1 until the second write cycle ends.
- Assert rst mid-drain with count=3 -> outputs immediately 0, count=0, no further reg_write. After release, a new x9=0x55 is written normally.
